// File: rtl/fa_bist_pkg.sv
// Shared types and the golden full-adder function for the full-adder self-test engine.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  // Returns {co,sum} of a 1-bit full adder.
  function automatic logic [1:0] fa_expect(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Combinational golden full adder that the checker compares the silicon adder against.
module fa_ref_model
  import fa_bist_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic co
);

  assign {co, sum} = fa_expect(a, b, c);

endmodule

// File: rtl/fa_bist_checker.sv
// Self-test engine: sweeps all {A,B,C} vectors into a full adder, compares the
// response with the golden model, counts mismatches and captures the first failure.
module fa_bist_checker
  import fa_bist_pkg::*;
#(
  parameter int DUT_LAT    = 1,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       fail_vec,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_co
);

  localparam int WAIT_W = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DUT_LAT);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
  localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic [VEC_W-1:0]  vec;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PASS_W-1:0] pass_cnt;

  logic exp_sum;
  logic exp_co;
  logic mismatch;

  logic start_run;
  logic abort_run;
  logic sample;
  logic last_sample;
  logic complete;

  // The vector register drives the adder directly; it is 0 whenever no run is active.
  assign {fa_a, fa_b, fa_c} = vec;

  fa_ref_model u_ref (
    .a   (fa_a),
    .b   (fa_b),
    .c   (fa_c),
    .sum (exp_sum),
    .co  (exp_co)
  );

  assign mismatch = ({fa_co, fa_sum} != {exp_co, exp_sum});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_run   = 1'b0;
    abort_run   = 1'b0;
    sample      = 1'b0;
    last_sample = 1'b0;
    complete    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort wins over a sample falling on the same edge.
        if (abort) begin
          state_nxt = ST_IDLE;
          abort_run = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          sample = 1'b1;
          if ((vec == LAST_VEC) && (pass_cnt == PASS_LAST)) begin
            last_sample = 1'b1;
            state_nxt   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        complete  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      wait_cnt <= '0;
      pass_cnt <= '0;
    end else if (start_run || abort_run) begin
      vec      <= '0;
      wait_cnt <= '0;
      pass_cnt <= '0;
    end else if (sample) begin
      vec      <= vec + VEC_W'(1);
      wait_cnt <= '0;
      if (vec == LAST_VEC) begin
        pass_cnt <= pass_cnt + PASS_W'(1);
      end
    end else if (state == ST_RUN) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Capture keeps working after the error counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (start_run) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (sample && mismatch) begin
      if (err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_vec   <= vec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= complete;
      if (start_run) begin
        busy <= 1'b1;
        pass <= 1'b0;
      end else if (abort_run || last_sample) begin
        busy <= 1'b0;
      end
      if (complete) begin
        pass <= (err_cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Scoreboard bench for fa_bist_checker: three instances cover latency 0/2,
// multi-pass saturation, and faulty adders selected by the bench.
module tb_fa_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0;
  int nfail  = 0;
  int mode   = 0;   // u0 adder: 0 correct, 1 sum stuck-at-0, 2 co inverted
  int dcnt0  = 0;

  typedef struct {
    int tag;
    int pass;
    int err;
    int fv;
    int fvec;
    int dcyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t m0, m1, m2;

  // u0: DUT_LAT=0, one pass, ERR_W=4, combinational adder with selectable fault
  logic start0, abort0, busy0, done0, pass0, fv0, a0, b0, c0, sum0, co0;
  logic [3:0] err0;
  logic [2:0] fvec0;
  assign sum0 = (mode == 1) ? 1'b0 : (a0 ^ b0 ^ c0);
  assign co0  = ((a0 & b0) | (a0 & c0) | (b0 & c0)) ^ (mode == 2);

  // u1: DUT_LAT=0, two passes, ERR_W=2, co inverted
  logic start1, abort1, busy1, done1, pass1, fv1, a1, b1, c1, sum1, co1;
  logic [1:0] err1;
  logic [2:0] fvec1;
  assign sum1 = a1 ^ b1 ^ c1;
  assign co1  = ~((a1 & b1) | (a1 & c1) | (b1 & c1));

  // u2: DUT_LAT=2, two-stage registered correct adder
  logic start2, abort2, busy2, done2, pass2, fv2, a2, b2, c2, sum2, co2;
  logic [3:0] err2;
  logic [2:0] fvec2;
  logic [1:0] st1, st2;
  always @(posedge clk) begin
    st1 <= {((a2 & b2) | (a2 & c2) | (b2 & c2)), (a2 ^ b2 ^ c2)};
    st2 <= st1;
  end
  assign {co2, sum2} = st2;

  fa_bist_checker #(.DUT_LAT(0), .NUM_PASSES(1), .ERR_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .busy(busy0),
    .done(done0), .pass(pass0), .err_cnt(err0), .fail_valid(fv0), .fail_vec(fvec0),
    .fa_a(a0), .fa_b(b0), .fa_c(c0), .fa_sum(sum0), .fa_co(co0));

  fa_bist_checker #(.DUT_LAT(0), .NUM_PASSES(2), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1), .fail_valid(fv1), .fail_vec(fvec1),
    .fa_a(a1), .fa_b(b1), .fa_c(c1), .fa_sum(sum1), .fa_co(co1));

  fa_bist_checker #(.DUT_LAT(2), .NUM_PASSES(1), .ERR_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err2), .fail_valid(fv2), .fail_vec(fvec2),
    .fa_a(a2), .fa_b(b2), .fa_c(c2), .fa_sum(sum2), .fa_co(co2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare(input string nm, input exp_t e, input logic p,
                         input logic [31:0] er, input logic f, input logic [2:0] fvv);
    check($sformatf("%s_run%0d_cycle", nm, e.tag), cyc, e.dcyc);
    check($sformatf("%s_run%0d_pass", nm, e.tag), {31'd0, p}, e.pass);
    check($sformatf("%s_run%0d_err_cnt", nm, e.tag), er, e.err);
    check($sformatf("%s_run%0d_fail_valid", nm, e.tag), {31'd0, f}, e.fv);
    check($sformatf("%s_run%0d_fail_vec", nm, e.tag), {29'd0, fvv}, e.fvec);
  endtask

  task automatic spurious(input string nm);
    ntests++;
    nfail++;
    $display("FAIL %s_done: got done=1 expected no pending run (cycle %0d)", nm, cyc);
  endtask

  // Monitors: pop the expected result whenever a done pulse appears.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      dcnt0++;
      if (q0.size() == 0) spurious("u0");
      else begin
        m0 = q0.pop_front();
        compare("u0", m0, pass0, {28'd0, err0}, fv0, fvec0);
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) spurious("u1");
      else begin
        m1 = q1.pop_front();
        compare("u1", m1, pass1, {30'd0, err1}, fv1, fvec1);
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) spurious("u2");
      else begin
        m2 = q2.pop_front();
        compare("u2", m2, pass2, {28'd0, err2}, fv2, fvec2);
      end
    end
  end

  // Pulse start on one instance for a cycle, optionally queuing its expected result.
  task automatic go(input int which, input bit push, input int tag, input int p,
                    input int er, input int f, input int fvv, input int lat);
    exp_t e;
    e.tag  = tag;
    e.pass = p;
    e.err  = er;
    e.fv   = f;
    e.fvec = fvv;
    e.dcyc = cyc + 1 + lat;
    case (which)
      0: begin start0 = 1'b1; if (push) q0.push_back(e); end
      1: begin start1 = 1'b1; if (push) q1.push_back(e); end
      default: begin start2 = 1'b1; if (push) q2.push_back(e); end
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_q(input int which);
    int n;
    int k;
    k = 0;
    n = 1;
    while (k < 400) begin
      case (which)
        0: n = q0.size();
        1: n = q1.size();
        default: n = q2.size();
      endcase
      if (n == 0) k = 400;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (n != 0) begin
      ntests++;
      nfail++;
      $display("FAIL u%0d_timeout: got %0d pending results expected 0", which, n);
      case (which)
        0: q0.delete();
        1: q1.delete();
        default: q2.delete();
      endcase
    end
  endtask

  task automatic wait_vec0(input int v);
    int k;
    logic [2:0] tv;
    tv = v[2:0];
    k = 0;
    while (({a0, b0, c0} != tv) && (k < 20)) begin
      @(negedge clk);
      k++;
    end
    check("u0_reach_vec", {29'd0, a0, b0, c0}, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    check("rst_pass", {31'd0, pass0}, 0);
    check("rst_err_cnt", {28'd0, err0}, 0);
    check("rst_fail_valid", {31'd0, fv0}, 0);
    check("rst_fail_vec", {29'd0, fvec0}, 0);
    check("rst_fa", {29'd0, a0, b0, c0}, 0);
    check("rst_u1_busy", {31'd0, busy1}, 0);
    check("rst_u2_err_cnt", {28'd0, err2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct adder, one vector per cycle, done 9 cycles after the start edge
    go(0, 1, 1, 1, 0, 0, 0, 9);
    for (int i = 0; i < 8; i++) begin
      check("t1_sweep_fa", {29'd0, a0, b0, c0}, i);
      check("t1_busy", {31'd0, busy0}, 1);
      @(negedge clk);
    end
    check("t1_busy_fall", {31'd0, busy0}, 0);
    check("t1_fa_idle", {29'd0, a0, b0, c0}, 0);
    check("t1_done_not_yet", {31'd0, done0}, 0);
    wait_q(0);
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, done0}, 0);
    check("t1_pass_held", {31'd0, pass0}, 1);

    // Sum stuck-at-0: vectors 1,2,4,7 fail
    mode = 1;
    go(0, 1, 2, 0, 4, 1, 1, 9);
    wait_q(0);

    // Co inverted on every vector
    mode = 2;
    go(0, 1, 3, 0, 8, 1, 0, 9);
    wait_q(0);

    // Two passes with co inverted: 16 mismatches saturate a 2-bit counter
    go(1, 1, 4, 0, 3, 1, 0, 17);
    wait_q(1);

    // Latency 2: each vector held three cycles
    go(2, 1, 5, 1, 0, 0, 0, 25);
    for (int k = 0; k < 24; k++) begin
      check("t4_hold_fa", {29'd0, a2, b2, c2}, k / 3);
      @(negedge clk);
    end
    check("t4_busy_fall", {31'd0, busy2}, 0);
    wait_q(2);

    // Abort at vec=4 on the stuck-sum adder; the same-edge sample of vec 4 is dropped
    mode = 1;
    d = dcnt0;
    go(0, 0, 0, 0, 0, 0, 0, 0);
    wait_vec0(4);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("t5_abort_busy", {31'd0, busy0}, 0);
    check("t5_abort_fa", {29'd0, a0, b0, c0}, 0);
    check("t5_abort_err_cnt", {28'd0, err0}, 2);
    check("t5_abort_fail_valid", {31'd0, fv0}, 1);
    check("t5_abort_fail_vec", {29'd0, fvec0}, 1);
    check("t5_abort_pass", {31'd0, pass0}, 0);
    repeat (12) @(negedge clk);
    check("t5_no_done", dcnt0, d);
    mode = 0;
    go(0, 1, 6, 1, 0, 0, 0, 9);
    check("t5_restart_fa", {29'd0, a0, b0, c0}, 0);
    check("t5_restart_err_cnt", {28'd0, err0}, 0);
    check("t5_restart_fail_valid", {31'd0, fv0}, 0);
    wait_q(0);

    // Start while busy is ignored; reset at vec=5 clears everything at once
    d = dcnt0;
    go(0, 0, 0, 0, 0, 0, 0, 0);
    wait_vec0(2);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("t6_start_ignored_fa", {29'd0, a0, b0, c0}, 3);
    check("t6_still_busy", {31'd0, busy0}, 1);
    wait_vec0(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy0}, 0);
    check("t6_rst_fa", {29'd0, a0, b0, c0}, 0);
    check("t6_rst_pass", {31'd0, pass0}, 0);
    check("t6_rst_err_cnt", {28'd0, err0}, 0);
    check("t6_rst_fail_valid", {31'd0, fv0}, 0);
    check("t6_rst_done", {31'd0, done0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_no_done", dcnt0, d);
    check("t6_idle_busy", {31'd0, busy0}, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
